// File: rtl/apb_splitter_wdt.sv
// APB 1-to-N fan-out: base/mask address decode, combinational routing, error on decode miss.
// Define APB_SPLITTER_TIMEOUT_EN to add the access-phase stall watchdog.
module apb_splitter_wdt #(
    parameter int unsigned                N_SLAVES       = 2,
    parameter int unsigned                W_ADDR         = 16,
    parameter int unsigned                W_DATA         = 32,
    parameter logic [N_SLAVES*W_ADDR-1:0] ADDR_MAP       = {16'h4000, 16'h0000},
    parameter logic [N_SLAVES*W_ADDR-1:0] ADDR_MASK      = {16'hc000, 16'hc000},
    parameter int unsigned                W_TIMEOUT      = 8,
    parameter int unsigned                TIMEOUT_CYCLES = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [W_ADDR-1:0]          apbs_paddr,
    input  logic                       apbs_psel,
    input  logic                       apbs_penable,
    input  logic                       apbs_pwrite,
    input  logic [W_DATA-1:0]          apbs_pwdata,
    output logic                       apbs_pready,
    output logic [W_DATA-1:0]          apbs_prdata,
    output logic                       apbs_pslverr,
    output logic [W_ADDR-1:0]          apbm_paddr,
    output logic [N_SLAVES-1:0]        apbm_psel,
    output logic                       apbm_penable,
    output logic                       apbm_pwrite,
    output logic [W_DATA-1:0]          apbm_pwdata,
    input  logic [N_SLAVES-1:0]        apbm_pready,
    input  logic [N_SLAVES*W_DATA-1:0] apbm_prdata,
    input  logic [N_SLAVES-1:0]        apbm_pslverr,
    output logic                       timeout_flag
);

    logic                hit;
    logic [N_SLAVES-1:0] hit_onehot;
    logic                sel_pready;
    logic                sel_pslverr;
    logic [W_DATA-1:0]   sel_prdata;
    logic                in_access;
    logic                abort;
    logic                timeout_flag_d;
    logic                timeout_flag_q;

    assign apbm_paddr   = apbs_paddr;
    assign apbm_penable = apbs_penable;
    assign apbm_pwrite  = apbs_pwrite;
    assign apbm_pwdata  = apbs_pwdata;
    assign in_access    = apbs_psel & apbs_penable;

    // Scan from the highest index down so the lowest matching window is the one kept.
    always_comb begin
        hit         = 1'b0;
        hit_onehot  = '0;
        sel_pready  = 1'b0;
        sel_pslverr = 1'b0;
        sel_prdata  = '0;
        for (int i = int'(N_SLAVES) - 1; i >= 0; i--) begin
            if ((apbs_paddr & ADDR_MASK[i*W_ADDR +: W_ADDR]) ==
                (ADDR_MAP[i*W_ADDR +: W_ADDR] & ADDR_MASK[i*W_ADDR +: W_ADDR])) begin
                hit           = 1'b1;
                hit_onehot    = '0;
                hit_onehot[i] = 1'b1;
                sel_pready    = apbm_pready[i];
                sel_pslverr   = apbm_pslverr[i];
                sel_prdata    = apbm_prdata[i*W_DATA +: W_DATA];
            end
        end
    end

`ifdef APB_SPLITTER_TIMEOUT_EN
    logic [W_TIMEOUT-1:0] stall_cnt_d;
    logic [W_TIMEOUT-1:0] stall_cnt_q;

    // The limit check precedes the ready check: a slave answering on the abort cycle loses.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        abort       = 1'b0;
        if (!in_access || !hit) begin
            stall_cnt_d = '0;
        end else if (stall_cnt_q == W_TIMEOUT'(TIMEOUT_CYCLES)) begin
            abort       = 1'b1;
            stall_cnt_d = '0;
        end else if (sel_pready) begin
            stall_cnt_d = '0;
        end else if (stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + W_TIMEOUT'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end
`else
    // Watchdog sizing has no effect when the watchdog is not built.
    localparam int unsigned WDT_CFG_UNUSED = W_TIMEOUT + TIMEOUT_CYCLES;

    assign abort = 1'b0;
`endif

    assign timeout_flag_d = abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_flag_q <= 1'b0;
        end else begin
            timeout_flag_q <= timeout_flag_d;
        end
    end

    assign timeout_flag = timeout_flag_q;

    always_comb begin
        apbm_psel    = '0;
        apbs_pready  = 1'b1;
        apbs_pslverr = 1'b0;
        apbs_prdata  = '0;
        if (apbs_psel) begin
            if (abort) begin
                apbs_pslverr = 1'b1;
            end else if (hit) begin
                apbm_psel    = hit_onehot;
                apbs_pready  = sel_pready;
                apbs_pslverr = sel_pslverr;
                apbs_prdata  = sel_prdata;
            end else begin
                apbs_pslverr = apbs_penable;
            end
        end
    end

endmodule

// File: tb/tb_apb_splitter_wdt.sv
// Randomised bench for apb_splitter_wdt against a transfer-level reference model.
`timescale 1ns/1ps
module tb_apb_splitter_wdt;

    localparam int N    = 2;
    localparam int WA   = 16;
    localparam int WD   = 32;
    localparam int WT   = 8;
    localparam int TO   = 4;
    localparam int MAXC = 400;
`ifdef APB_SPLITTER_TIMEOUT_EN
    localparam bit WDT = 1'b1;
`else
    localparam bit WDT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [WA-1:0] paddr;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [WD-1:0] pwdata;
    logic          apbs_pready;
    logic [WD-1:0] apbs_prdata;
    logic          apbs_pslverr;
    logic [WA-1:0] apbm_paddr;
    logic [N-1:0]  apbm_psel;
    logic          apbm_penable;
    logic          apbm_pwrite;
    logic [WD-1:0] apbm_pwdata;
    logic [N-1:0]  m_pready;
    logic [N*WD-1:0] m_prdata;
    logic [N-1:0]  m_pslverr;
    logic          timeout_flag;

    int n_tests = 0;
    int n_fail  = 0;
    bit flag_exp = 1'b0;

    always #5 clk = ~clk;

    apb_splitter_wdt #(
        .N_SLAVES(N), .W_ADDR(WA), .W_DATA(WD),
        .ADDR_MAP({16'h4000, 16'h0000}), .ADDR_MASK({16'hc000, 16'hc000}),
        .W_TIMEOUT(WT), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .apbs_paddr(paddr), .apbs_psel(psel), .apbs_penable(penable),
        .apbs_pwrite(pwrite), .apbs_pwdata(pwdata),
        .apbs_pready(apbs_pready), .apbs_prdata(apbs_prdata), .apbs_pslverr(apbs_pslverr),
        .apbm_paddr(apbm_paddr), .apbm_psel(apbm_psel), .apbm_penable(apbm_penable),
        .apbm_pwrite(apbm_pwrite), .apbm_pwdata(apbm_pwdata),
        .apbm_pready(m_pready), .apbm_prdata(m_prdata), .apbm_pslverr(m_pslverr),
        .timeout_flag(timeout_flag)
    );

    // Address map of the bench: first matching window wins, -1 for a miss.
    function automatic int decode(input logic [WA-1:0] a);
        logic [WA-1:0] base [N];
        logic [WA-1:0] mask [N];
        base[0] = 16'h0000; mask[0] = 16'hc000;
        base[1] = 16'h4000; mask[1] = 16'hc000;
        for (int i = 0; i < N; i++)
            if ((a & mask[i]) == (base[i] & mask[i])) return i;
        return -1;
    endfunction

    task automatic rand_slaves();
        m_pready  = N'($urandom);
        m_pslverr = N'($urandom);
        for (int i = 0; i < N; i++) m_prdata[i*WD +: WD] = $urandom;
    endtask

    // One upstream transfer; target slave waits wait_n access cycles, cut>0 abandons after cut access cycles.
    task automatic xfer(input string name, input logic [WA-1:0] a, input int wait_n,
                        input bit err, input logic [WD-1:0] rdat, input int cut);
        int k;
        int n;
        bit done;
        bit ab;
        bit rdy;
        bit er;
        logic [N-1:0]  sel;
        logic [WD-1:0] rd;
        k = decode(a);
        n = 0;
        done = 1'b0;
        paddr  = a;
        pwrite = 1'($urandom);
        pwdata = $urandom;
        psel   = 1'b1;
        while (!done) begin
            penable = (n > 0);
            rand_slaves();
            if (k >= 0 && n > 0) begin
                m_pready[k] = (n > wait_n);
                if (n > wait_n) begin
                    m_pslverr[k] = err;
                    m_prdata[k*WD +: WD] = rdat;
                end
            end
            ab = WDT && k >= 0 && n == TO + 1;
            if (ab) begin
                sel = '0; rdy = 1'b1; er = 1'b1; rd = '0;
            end else if (k < 0) begin
                sel = '0; rdy = 1'b1; er = (n > 0); rd = '0;
            end else begin
                sel = N'(1) << k;
                rdy = (n == 0) ? m_pready[k] : (n > wait_n);
                er  = m_pslverr[k];
                rd  = m_prdata[k*WD +: WD];
            end
            @(negedge clk);
            n_tests++;
            if ({apbm_psel, apbs_pready, apbs_pslverr} !== {sel, rdy, er}) begin
                n_fail++;
                $display("FAIL %s cyc %0d psel/pready/pslverr: got %b/%b/%b want %b/%b/%b",
                         name, n, apbm_psel, apbs_pready, apbs_pslverr, sel, rdy, er);
            end
            n_tests++;
            if (apbs_prdata !== rd) begin
                n_fail++;
                $display("FAIL %s cyc %0d prdata: got %h want %h", name, n, apbs_prdata, rd);
            end
            n_tests++;
            if (timeout_flag !== flag_exp) begin
                n_fail++;
                $display("FAIL %s cyc %0d timeout_flag: got %b want %b", name, n, timeout_flag, flag_exp);
            end
            n_tests++;
            if ({apbm_paddr, apbm_penable, apbm_pwrite, apbm_pwdata} !== {paddr, penable, pwrite, pwdata}) begin
                n_fail++;
                $display("FAIL %s cyc %0d passthrough: got %h/%b/%b/%h want %h/%b/%b/%h", name, n,
                         apbm_paddr, apbm_penable, apbm_pwrite, apbm_pwdata, paddr, penable, pwrite, pwdata);
            end
            flag_exp = ab;
            done = (n > 0 && rdy) || (cut > 0 && n == cut);
            @(posedge clk); #1;
            n++;
            if (!done && n > MAXC) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s completion: got none after %0d cycles want pready", name, MAXC);
                done = 1'b1;
            end
        end
    endtask

    task automatic idle(input int cycles);
        logic [N+1+1+WD-1:0] exp_idle;
        exp_idle = '0;
        exp_idle[WD+1] = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            psel = 1'b0; penable = 1'b0; paddr = WA'($urandom);
            rand_slaves();
            @(negedge clk);
            n_tests++;
            if ({apbm_psel, apbs_pready, apbs_pslverr, apbs_prdata} !== exp_idle) begin
                n_fail++;
                $display("FAIL idle outputs: got %h want %h",
                         {apbm_psel, apbs_pready, apbs_pslverr, apbs_prdata}, exp_idle);
            end
            n_tests++;
            if (timeout_flag !== flag_exp) begin
                n_fail++;
                $display("FAIL idle timeout_flag: got %b want %b", timeout_flag, flag_exp);
            end
            flag_exp = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic reset_pulse(input string name);
        logic [N+1+1+WD-1:0] exp_idle;
        exp_idle = '0;
        exp_idle[WD+1] = 1'b1;
        rst_n = 1'b0; psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        n_tests++;
        if (timeout_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL %s timeout_flag: got %b want 0", name, timeout_flag);
        end
        n_tests++;
        if ({apbm_psel, apbs_pready, apbs_pslverr, apbs_prdata} !== exp_idle) begin
            n_fail++;
            $display("FAIL %s outputs: got %h want %h", name,
                     {apbm_psel, apbs_pready, apbs_pslverr, apbs_prdata}, exp_idle);
        end
        flag_exp = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; paddr = '0; pwrite = 1'b0; pwdata = '0;
        rand_slaves();
        repeat (2) @(posedge clk);
        #1;
        reset_pulse("reset");
        idle(1);
    endtask

    task automatic test_slave1_read();
        xfer("slave1_read", 16'h4010, 0, 1'b0, 32'hdeadbeef, 0);
        idle(1);
    endtask

    task automatic test_miss();
        xfer("miss", 16'h8000, 0, 1'b0, 32'h0, 0);
        xfer("miss_hi", 16'hc123, 0, 1'b0, 32'h0, 0);
        idle(1);
    endtask

    task automatic test_stall_err();
        xfer("slave0_stall_err", 16'h0004, 3, 1'b1, $urandom, 0);
        idle(2);
    endtask

    task automatic test_timeout();
`ifdef APB_SPLITTER_TIMEOUT_EN
        xfer("abort", 16'h0100, 1000, 1'b0, $urandom, 0);
        idle(2);
        xfer("abort_b2b_1", 16'h4100, 1000, 1'b1, $urandom, 0);
        xfer("abort_b2b_2", 16'h4104, TO, 1'b0, $urandom, 0);
        idle(2);
`else
        xfer("long_stall", 16'h0100, 20, 1'b0, $urandom, 0);
        idle(2);
`endif
    endtask

    task automatic test_ready_at_limit();
        xfer("ready_at_limit", 16'h0008, TO - 1, 1'b0, $urandom, 0);
        xfer("b2b_after_limit", 16'h4008, TO - 1, 1'b0, $urandom, 0);
        idle(1);
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 60; t++) begin
            xfer("random", WA'($urandom), $urandom_range(0, TO + 2), 1'($urandom), $urandom, 0);
            if ($urandom_range(0, 2) == 0) idle(1);
        end
        idle(2);
    endtask

    task automatic test_reset_mid_stall();
`ifdef APB_SPLITTER_TIMEOUT_EN
        xfer("abort_then_reset", 16'h0040, 1000, 1'b0, $urandom, 0);
`else
        xfer("xfer_then_reset", 16'h0040, 1, 1'b0, $urandom, 0);
`endif
        reset_pulse("reset_after_xfer");
        xfer("stall_then_reset", 16'h4040, 1000, 1'b0, $urandom, 3);
        reset_pulse("reset_mid_stall");
        xfer("after_reset", 16'h0044, TO - 1, 1'b0, $urandom, 0);
        idle(2);
    endtask

    initial begin
        test_reset();
        test_slave1_read();
        test_miss();
        test_stall_err();
        test_timeout();
        test_ready_at_limit();
        test_back_to_back();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish want finish before 1ms");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/apb_splitter_wdt.md
# apb_splitter_wdt

APB fan-out stage sitting directly downstream of the AHB-Lite-to-APB bridge: one APB slave port in, N_SLAVES APB master ports out. Decodes each transfer's address against per-slave base/mask windows, routes select and response with zero added latency, and answers decode misses with an error. An optional per-transfer watchdog aborts access phases that stall too long and returns an error upstream, so one hung peripheral cannot lock the AHB-Lite bus.

## Interface
Parameters:
- N_SLAVES, 2: number of downstream ports (1..16)
- W_ADDR, 16: APB address width
- W_DATA, 32: APB data width
- ADDR_MAP, {16'h4000, 16'h0000}: N_SLAVES×W_ADDR packed bases; slave i at bits [i*W_ADDR +: W_ADDR]
- ADDR_MASK, {16'hc000, 16'hc000}: N_SLAVES×W_ADDR packed masks, same packing
- W_TIMEOUT, 8: watchdog counter width
- TIMEOUT_CYCLES, 255: stalled access cycles before abort (1..2^W_TIMEOUT-1)

Ports (reset rst_n, asynchronous, active-low; clock clk):
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- apbs_paddr  in  W_ADDR  upstream address
- apbs_psel  in  1  upstream select
- apbs_penable  in  1  upstream enable
- apbs_pwrite  in  1  upstream write
- apbs_pwdata  in  W_DATA  upstream write data
- apbs_pready  out  1  upstream ready
- apbs_prdata  out  W_DATA  upstream read data
- apbs_pslverr  out  1  upstream error
- apbm_paddr  out  W_ADDR  shared downstream address (= apbs_paddr)
- apbm_psel  out  N_SLAVES  one-hot downstream selects
- apbm_penable  out  1  shared enable (= apbs_penable)
- apbm_pwrite  out  1  shared write (= apbs_pwrite)
- apbm_pwdata  out  W_DATA  shared write data (= apbs_pwdata)
- apbm_pready  in  N_SLAVES  per-slave ready
- apbm_prdata  in  N_SLAVES×W_DATA  per-slave read data, packed as ADDR_MAP
- apbm_pslverr  in  N_SLAVES  per-slave error
- timeout_flag  out  1  registered one-cycle pulse per watchdog abort

## Operation
- Decode: slave i hits when (apbs_paddr & MASK_i) == (BASE_i & MASK_i); overlapping windows resolve to lowest index.
- Hit on slave k: apbm_psel = apbs_psel << k; apbs_pready/prdata/pslverr = slave k's signals.
- Miss: apbm_psel = 0; apbs_pready = 1, apbs_pslverr = apbs_psel & apbs_penable, apbs_prdata = 0.
- apbs_psel low: apbm_psel = 0, apbs_pready = 1, apbs_pslverr = 0, apbs_prdata = 0.
- Watchdog state: IDLE (psel low), SETUP (psel & !penable), ACCESS (psel & penable). Counter `stall_cnt` cleared in IDLE/SETUP and on any cycle where selected pready = 1; increments (saturating) each ACCESS cycle with selected pready = 0 on a hit.
- Abort: when stall_cnt == TIMEOUT_CYCLES in ACCESS and selected pready still 0: force apbs_pready = 1, apbs_pslverr = 1, apbs_prdata = 0, apbm_psel = 0 that cycle; timeout_flag = 1 next cycle; stall_cnt cleared.
- Slave pready arriving on the abort cycle: abort wins (error returned, slave's data discarded).
- Misses never time out (complete in their first access cycle).
- Reset: stall_cnt = 0, timeout_flag = 0; combinational outputs follow the idle rules above. Reset mid-transfer abandons it; no state survives.

## Timing
- Zero added latency: all routing paths combinational; only stall_cnt and timeout_flag are registered.
- Transfer with slave pready = 1 on first access cycle: 2 cycles, as at bridge.
- Abort occurs on the (TIMEOUT_CYCLES+1)th access cycle; upstream sees exactly one access cycle with pready = 1.
- Back-to-back transfers (SETUP directly after completing ACCESS): stall_cnt starts from 0.

## Configuration
- APB_SPLITTER_TIMEOUT_EN defined: watchdog as described.
- Not defined: no counter, no abort; access phases stall indefinitely on slave pready = 0; timeout_flag tied 0; W_TIMEOUT/TIMEOUT_CYCLES ignored.

## Test plan
- Read 0x4010 (slave 1), slave returns pready = 1, prdata = 0xdeadbeef -> apbm_psel = 2'b10 for 2 cycles, apbs_prdata = 0xdeadbeef, pslverr = 0.
- Write 0x8000 (miss) -> apbm_psel = 0 throughout, access cycle pready = 1, pslverr = 1.
- Read 0x0004, slave 0 stalls 3 cycles then pslverr = 1 -> upstream sees 3 wait cycles then pready = 1, pslverr = 1; timeout_flag stays 0.
- TIMEOUT_CYCLES = 4, slave 0 never ready -> abort on 5th access cycle: pready = 1, pslverr = 1, apbm_psel drops; timeout_flag pulses once next cycle.
- TIMEOUT_CYCLES = 4, slave ready exactly on 4th access cycle -> normal completion, no error, no flag; following transfer starts with counter 0.
- rst_n asserted mid-stall -> timeout_flag = 0, stall_cnt = 0; after release, new transfer completes normally.
